// File: rtl/wchb_sync_arbiter.sv
// Round-robin front-end sharing one WCHB input channel between N_REQ clocked
// requesters; drives a bundled-data 4-phase handshake and syncs the ack back in.
module wchb_sync_arbiter #(
   parameter int N_REQ       = 4,
   parameter int DATA_W      = 32,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        i_req,
   input  logic [N_REQ*DATA_W-1:0] i_data,
   output logic [N_REQ-1:0]        o_grant,
   output logic                    o_busy,
   output logic                    o_areq,
   output logic [DATA_W-1:0]       o_adata,
   input  logic                    i_aack,
   output logic                    o_timeout
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int SUM_W = IDX_W + 1;
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = (TIMEOUT > 0) ? CNT_W'(TIMEOUT) : '1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_REQ,
      S_RELEASE,
      S_DONE
   } state_t;

   state_t                        r_state;
   logic [IDX_W-1:0]              r_rr_ptr;
   logic [IDX_W-1:0]              r_sel;
   logic [CNT_W-1:0]              r_cnt;
   logic [SYNC_STAGES-1:0]        r_sync;
   logic [N_REQ-1:0]              r_grant;
   logic                          r_areq;
   logic [DATA_W-1:0]             r_adata;
   logic                          r_timeout;

   logic [N_REQ-1:0][DATA_W-1:0]  w_slices;
   logic                          w_ack_s;
   logic                          w_any;
   logic [IDX_W-1:0]              w_win;
   logic                          w_waiting;

   assign w_slices  = i_data;
   assign w_ack_s   = r_sync[SYNC_STAGES-1];
   assign w_any     = |i_req;
   assign w_waiting = (r_state == S_REQ) || (r_state == S_RELEASE);

   // Ack crosses from the async pipeline; only the last flop is ever observed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_sync <= '0;
      else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_aack};
   end

   // Rotating-priority scan starting at r_rr_ptr, wrapping modulo N_REQ.
   always_comb begin
      logic [SUM_W-1:0] sum;
      logic             found;
      w_win = r_rr_ptr;
      found = 1'b0;
      sum   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         sum = {1'b0, r_rr_ptr} + SUM_W'(i);
         if (sum >= SUM_W'(N_REQ)) sum = sum - SUM_W'(N_REQ);
         if (!found && i_req[sum[IDX_W-1:0]]) begin
            found = 1'b1;
            w_win = sum[IDX_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_rr_ptr  <= '0;
         r_sel     <= '0;
         r_cnt     <= '0;
         r_grant   <= '0;
         r_areq    <= 1'b0;
         r_adata   <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_grant <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_adata <= w_slices[w_win];
                  r_sel   <= w_win;
                  r_state <= S_SETUP;
               end
            end
            S_SETUP: begin
               // Data has been stable for a full cycle before the request edge.
               r_state <= S_REQ;
               r_areq  <= 1'b1;
               r_cnt   <= '0;
            end
            S_REQ: begin
               if (w_ack_s) begin
                  r_state <= S_RELEASE;
                  r_areq  <= 1'b0;
                  r_cnt   <= '0;
               end else if (r_cnt != CNT_MAX) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_RELEASE: begin
               if (!w_ack_s) begin
                  r_state        <= S_DONE;
                  r_grant[r_sel] <= 1'b1;
               end else if (r_cnt != CNT_MAX) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               r_rr_ptr <= (r_sel == LAST_IDX) ? '0 : r_sel + 1'b1;
               r_state  <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_areq  <= 1'b0;
            end
         endcase
         // Only flags a late ack edge; the handshake itself is never abandoned.
         if (TIMEOUT != 0 && w_waiting && r_cnt == CNT_MAX)
            r_timeout <= 1'b1;
      end
   end

   assign o_grant   = r_grant;
   assign o_busy    = (r_state != S_IDLE);
   assign o_areq    = r_areq;
   assign o_adata   = r_adata;
   assign o_timeout = r_timeout;

endmodule

// File: tb/tb_wchb_sync_arbiter.sv
// Directed bench: instance A (TIMEOUT=0, loopback or manual ack) and
// instance B (TIMEOUT=8, manual ack) share clk/rst.
module tb_wchb_sync_arbiter;

   logic              clk = 1'b0;
   logic              rst;
   logic [3:0]        req_a, req_b;
   logic [3:0][31:0]  data_a, data_b;
   logic [3:0]        grant_a, grant_b;
   logic              busy_a, busy_b, areq_a, areq_b, to_a, to_b;
   logic [31:0]       adata_a, adata_b;
   logic              loop_a, man_a, ack_b, aack_a;
   int                n_chk = 0;
   int                n_err = 0;

   always #5 clk = ~clk;
   assign aack_a = loop_a ? areq_a : man_a;

   wchb_sync_arbiter #(.N_REQ(4), .DATA_W(32), .SYNC_STAGES(2), .TIMEOUT(0)) dut_a (
      .clk(clk), .rst(rst), .i_req(req_a), .i_data(data_a), .o_grant(grant_a),
      .o_busy(busy_a), .o_areq(areq_a), .o_adata(adata_a), .i_aack(aack_a),
      .o_timeout(to_a));

   wchb_sync_arbiter #(.N_REQ(4), .DATA_W(32), .SYNC_STAGES(2), .TIMEOUT(8)) dut_b (
      .clk(clk), .rst(rst), .i_req(req_b), .i_data(data_b), .o_grant(grant_b),
      .o_busy(busy_b), .o_areq(areq_b), .o_adata(adata_b), .i_aack(ack_b),
      .o_timeout(to_b));

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, act, exp);
      end
   endtask

   // Returns negedge count to the first grant pulse (-1 on expiry) and areq-high count.
   task automatic wait_grant(input bit use_b, output int cyc, output logic [3:0] g,
                             output int areq_cnt);
      bit done = 1'b0;
      cyc = -1; g = '0; areq_cnt = 0;
      for (int i = 1; i <= 400 && !done; i++) begin
         @(negedge clk);
         if ((use_b ? areq_b : areq_a) == 1'b1) areq_cnt++;
         if ((use_b ? grant_b : grant_a) != 4'b0) begin
            cyc  = i;
            g    = use_b ? grant_b : grant_a;
            done = 1'b1;
         end
      end
   endtask

   task automatic wait_areq(input bit use_b, input logic val, input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if ((use_b ? areq_b : areq_a) == val) ok = 1'b1;
      end
      check(tag, 64'(ok), 64'd1);
   endtask

   initial begin
      int         cyc, ac;
      logic [3:0] g;
      bit         stable, nogrant;

      rst = 1'b1; req_a = '0; req_b = '0; loop_a = 1'b1; man_a = 1'b0; ack_b = 1'b0;
      for (int k = 0; k < 4; k++) begin
         data_a[k] = 32'hA000_0000 | 32'(k);
         data_b[k] = 32'hB000_0000 | 32'(k);
      end
      repeat (3) @(negedge clk);
      check("rst_areq", 64'(areq_a), 64'd0);
      check("rst_grant", 64'(grant_a), 64'd0);
      check("rst_busy", 64'(busy_a), 64'd0);
      check("rst_timeout", 64'(to_b), 64'd0);
      check("rst_adata", 64'(adata_a), 64'd0);
      rst = 1'b0;

      // Fairness: all held, rotation 0,1,2,3,0,1 every 9 cycles.
      req_a = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         wait_grant(1'b0, cyc, g, ac);
         check($sformatf("rr_grant%0d", k), 64'(g), 64'(4'b0001 << (k % 4)));
         check($sformatf("rr_gap%0d", k), 64'(cyc), (k == 0) ? 64'd8 : 64'd9);
         check($sformatf("rr_data%0d", k), 64'(adata_a), 64'(data_a[k % 4]));
      end
      req_a = 4'b0000;
      repeat (3) @(negedge clk);

      // Single request, latency and areq width.
      data_a[2] = 32'hCAFE_0002;
      req_a     = 4'b0100;
      @(negedge clk);
      check("one_setup_adata", 64'(adata_a), 64'h0000_0000_CAFE_0002);
      check("one_setup_areq", 64'(areq_a), 64'd0);
      check("one_busy", 64'(busy_a), 64'd1);
      wait_grant(1'b0, cyc, g, ac);
      req_a = 4'b0000;
      check("one_grant", 64'(g), 64'(4'b0100));
      check("one_latency", 64'(cyc + 1), 64'd8);
      check("one_areq_cycles", 64'(ac), 64'd3);
      check("one_adata_done", 64'(adata_a), 64'h0000_0000_CAFE_0002);

      // Wrap: rr_ptr=3 now, so 3 wins over 0, then 0.
      req_a = 4'b1001;
      wait_grant(1'b0, cyc, g, ac);
      check("wrap_first", 64'(g), 64'(4'b1000));
      req_a = 4'b0001;
      wait_grant(1'b0, cyc, g, ac);
      check("wrap_second", 64'(g), 64'(4'b0001));
      req_a = 4'b0000;
      repeat (2) @(negedge clk);

      // Slow ack on each edge, no timeout configured.
      loop_a    = 1'b0;
      data_a[1] = 32'hDEAD_BEEF;
      req_a     = 4'b0010;
      wait_areq(1'b0, 1'b1, "slow_areq_rise");
      stable = 1'b1; nogrant = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (adata_a !== 32'hDEAD_BEEF) stable = 1'b0;
         if (grant_a !== 4'b0 || areq_a !== 1'b1) nogrant = 1'b0;
      end
      man_a = 1'b1;
      wait_areq(1'b0, 1'b0, "slow_areq_fall");
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (adata_a !== 32'hDEAD_BEEF) stable = 1'b0;
         if (grant_a !== 4'b0) nogrant = 1'b0;
      end
      check("slow_adata_stable", 64'(stable), 64'd1);
      check("slow_no_early_grant", 64'(nogrant), 64'd1);
      man_a = 1'b0;
      wait_grant(1'b0, cyc, g, ac);
      req_a = 4'b0000;
      check("slow_grant", 64'(g), 64'(4'b0010));
      check("slow_timeout", 64'(to_a), 64'd0);
      loop_a = 1'b1;

      // Timeout on instance B with ack stuck low.
      req_b = 4'b0001;
      wait_areq(1'b1, 1'b1, "to_areq_rise");
      repeat (8) @(negedge clk);
      check("to_not_yet", 64'(to_b), 64'd0);
      @(negedge clk);
      check("to_set", 64'(to_b), 64'd1);
      repeat (10) @(negedge clk);
      check("to_sticky", 64'(to_b), 64'd1);
      check("to_areq_held", 64'(areq_b), 64'd1);
      ack_b = 1'b1;
      wait_areq(1'b1, 1'b0, "to_areq_fall");
      ack_b = 1'b0;
      wait_grant(1'b1, cyc, g, ac);
      req_b = 4'b0000;
      check("to_grant", 64'(g), 64'(4'b0001));
      check("to_after_grant", 64'(to_b), 64'd1);

      // Reset while in REQ, then clean restart.
      data_a[1] = 32'h1234_5678;
      req_a     = 4'b0010;
      wait_areq(1'b0, 1'b1, "mid_areq_rise");
      rst = 1'b1;
      #1;
      check("mid_rst_areq", 64'(areq_a), 64'd0);
      check("mid_rst_busy", 64'(busy_a), 64'd0);
      check("mid_rst_grant", 64'(grant_a), 64'd0);
      check("mid_rst_rrptr", 64'(dut_a.r_rr_ptr), 64'd0);
      check("mid_rst_timeout_b", 64'(to_b), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      wait_grant(1'b0, cyc, g, ac);
      req_a = 4'b0000;
      check("restart_grant", 64'(g), 64'(4'b0010));
      check("restart_latency", 64'(cyc), 64'd8);
      check("restart_adata", 64'(adata_a), 64'h0000_0000_1234_5678);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
